pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Autonomous duty-cycle sequencer between the SPI register-write decoder and the PWM generator. It owns the `pwm_duty_cycle` value and can either take direct writes or ramp linearly from the current duty to a programmed target, one step per programmed interval. An optional bounce mode sweeps back and forth continuously. The SPI decoder forwards validated write transactions (addr, data) here, and `duty_out` drives the PWM generator in place of a static register.

## Interface
Parameters:
- `TICK_DIV`, 1000 — clk cycles per base tick (10 MHz → 10 kHz base tick); legal range 1..65535.
- `TICK_W`, 16 — prescaler counter width.

Ports:
- `clk` in 1 — system clock, 10 MHz.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `wr_valid` in 1 — one-cycle write strobe from SPI decoder.
- `wr_addr` in 7 — register address.
- `wr_data` in 8 — write data.
- `duty_out` out 8 — duty to PWM generator; registered.
- `busy` out 1 — high while state ≠ IDLE.
- `done` out 1 — one-cycle pulse when a forward-only ramp completes.
- `aborted` out 1 — one-cycle pulse when a running ramp is cancelled.

## Operation
Register map (writes only; any other address is ignored):
- `0x04 DUTY` — direct duty write. Sets `duty_out`. Aborts any ramp.
- `0x05 TARGET` — ramp end value.
- `0x06 STEP` — increment per step. A value of 0 is treated as 1.
- `0x07 DIV` — step interval = (DIV+1) base ticks.
- `0x08 CTRL`:
  - bit0 = start(1) / stop(0).
  - bit1 = bounce.
  - bits 7:2 ignored.

Reset values:
- `duty_out`=0, TARGET=0, STEP=1, DIV=0, bounce=0, state=IDLE.
- `busy`=0, `done`=0, `aborted`=0.

States:
- IDLE:
  - CTRL write with bit0=1 → latch `origin`=`duty_out`, clear prescaler and interval counter, go to FWD.
  - If TARGET == `duty_out` at start: no ramp; pulse `done` next cycle and stay IDLE.
- FWD (moving toward TARGET):
  - On each interval expiry, compute d = |TARGET − duty|.
  - If d ≤ STEP, `duty_out` = TARGET; otherwise move STEP toward TARGET.
  - The direction is re-evaluated on every step, so a TARGET change mid-ramp is honoured at the next step.
  - Arithmetic is 9-bit internally, and the result never leaves [0,255] (no wrap-around).
  - On reaching TARGET: if bounce=0, go to IDLE and pulse `done`; if bounce=1, go to REV.
- REV (bounce only): same step rule toward `origin`. On reaching `origin`, go to FWD. This cycles until stopped; `done` is never pulsed in bounce mode.
- Stop (CTRL bit0=0) while FWD/REV → IDLE, `duty_out` holds its current value, pulse `aborted`.
- DUTY write while FWD/REV → IDLE, `duty_out` = `wr_data`, pulse `aborted`. A DUTY write in IDLE does not pulse `aborted`.
- CTRL start while already FWD/REV → restart: re-latch `origin`, clear counters, go to FWD. No `aborted` pulse.
- TARGET/STEP/DIV writes never change state.

## Timing
- Write at cycle N (`wr_valid`=1) takes effect at N+1: register updated, state changed, `busy` reflects the new state.
- A direct DUTY write appears on `duty_out` at N+1.
- First ramp step: `duty_out` changes at cycle N+1+(DIV+1)·TICK_DIV. Subsequent steps occur every (DIV+1)·TICK_DIV cycles exactly, with no dead cycle at a FWD↔REV turnaround.
- `done` / `aborted` are asserted in the same cycle that `duty_out` / state shows the final value, for exactly one cycle.
- The prescaler runs only outside IDLE and is cleared on every start or restart.
- One write per cycle (guaranteed by the decoder). No back-pressure; writes are always accepted.
- Asynchronous reset mid-ramp returns all outputs to reset values immediately. No ramp resumes after reset release.

## Structure
- Package `pwm_cfg_pkg` holds:
  - Address constants `ADDR_DUTY`..`ADDR_CTRL` (0x04–0x08).
  - CTRL bit indices.
  - State enum {IDLE, FWD, REV}.
  - Reset constants for STEP/DIV.
- Sub-module `tick_prescaler` (params `TICK_DIV`, `TICK_W`):
  - Inputs: `clk`, `rst_n`, `clr`, `en`.
  - Output: one-cycle `tick` every TICK_DIV enabled cycles.
- `pwm_ramp_ctrl` instantiates `tick_prescaler` and implements the register file, interval counter, state machine, and step arithmetic.

## Test plan
Bench uses TICK_DIV=4.
- Ramp up: DUTY=0x10, TARGET=0x40, STEP=0x10, DIV=1, CTRL=0x01 at N → `duty_out` 0x20 at N+9, 0x30 at N+17, 0x40 at N+25. `done` pulses at N+25; `busy` drops at N+25.
- Saturation and down-ramp: DUTY=0xF8, TARGET=0x00, STEP=0x30, DIV=0 → sequence 0xC8, 0x98, 0x68, 0x38, 0x08, 0x00 with no wrap. Then TARGET=0xFF from 0xF0 with STEP=0x30 → single step to 0xFF.
- Bounce: DUTY=0x00, TARGET=0x03, STEP=1, CTRL=0x03 → 1,2,3,2,1,0,1… every 4 cycles. `done` never asserts. CTRL=0x00 mid-sweep → value held, `aborted` pulses, `busy`=0.
- Abort by DUTY write mid-ramp with data 0x77 → `duty_out`=0x77 next cycle, `aborted` pulses once, no further steps.
- Edge cases:
  - STEP=0 behaves as STEP=1.
  - Start with TARGET==duty → `done` at N+1, `busy` stays 0.
  - Unmapped address 0x09 has no effect.
  - `rst_n` low mid-ramp → `duty_out`=0 and state IDLE immediately; after release, no activity without a new start.

Source files
------------

// File: rtl/pwm_cfg_pkg.sv
// Shared register map, state encoding and step arithmetic for the PWM duty ramp sequencer.
package pwm_cfg_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 7'h04;
    localparam logic [ADDR_W-1:0] ADDR_TARGET = 7'h05;
    localparam logic [ADDR_W-1:0] ADDR_STEP   = 7'h06;
    localparam logic [ADDR_W-1:0] ADDR_DIV    = 7'h07;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 7'h08;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_BOUNCE_BIT = 1;

    localparam logic [DATA_W-1:0] STEP_RST = 8'd1;
    localparam logic [DATA_W-1:0] DIV_RST  = 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } ramp_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_txn_t;

    // One step from cur toward aim; lands exactly on aim when within stp, never wraps.
    function automatic logic [DATA_W-1:0] ramp_step(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] aim,
                                                    input logic [DATA_W-1:0] stp);
        logic [DATA_W:0] c9;
        logic [DATA_W:0] a9;
        logic [DATA_W:0] s9;
        logic [DATA_W:0] d9;
        c9 = (DATA_W+1)'(cur);
        a9 = (DATA_W+1)'(aim);
        s9 = (DATA_W+1)'(stp);
        d9 = (a9 >= c9) ? (a9 - c9) : (c9 - a9);
        if (d9 <= s9) begin
            return aim;
        end else if (a9 > c9) begin
            return DATA_W'(c9 + s9);
        end else begin
            return DATA_W'(c9 - s9);
        end
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick generator: one-cycle tick every TICK_DIV enabled clocks, restartable via clr.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned TICK_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + TICK_W'(1);
        end
    end

    // Decoded from the count so the step lands on the clock right after the last prescaled cycle.
    assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: direct writes, linear ramps toward TARGET, and optional bounce sweeping.
module pwm_ramp_ctrl
    import pwm_cfg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned TICK_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] duty_out,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    ramp_state_t       state_q,  state_d;
    logic [DATA_W-1:0] duty_q,   duty_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] step_q,   step_d;
    logic [DATA_W-1:0] div_q,    div_d;
    logic [DATA_W-1:0] origin_q, origin_d;
    logic [DATA_W-1:0] ival_q,   ival_d;
    logic              bounce_q, bounce_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              abort_q,  abort_d;

    wr_txn_t           wr_c;
    logic              wr_duty_c, wr_target_c, wr_step_c, wr_div_c, wr_ctrl_c;
    logic              start_c, running_c, tick_c, step_fire_c;
    logic [DATA_W-1:0] step_eff_c, aim_c, next_val_c;

    assign wr_c        = '{addr: wr_addr, data: wr_data};
    assign wr_duty_c   = wr_valid && (wr_c.addr == ADDR_DUTY);
    assign wr_target_c = wr_valid && (wr_c.addr == ADDR_TARGET);
    assign wr_step_c   = wr_valid && (wr_c.addr == ADDR_STEP);
    assign wr_div_c    = wr_valid && (wr_c.addr == ADDR_DIV);
    assign wr_ctrl_c   = wr_valid && (wr_c.addr == ADDR_CTRL);
    assign start_c     = wr_ctrl_c && wr_c.data[CTRL_START_BIT];
    assign running_c   = (state_q != IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_c),
        .en    (running_c),
        .tick  (tick_c)
    );

    // Step arithmetic: direction re-evaluated every step, so TARGET edits mid-ramp are honoured.
    assign step_eff_c  = (step_q == '0) ? DATA_W'(1) : step_q;
    assign aim_c       = (state_q == REV) ? origin_q : target_q;
    assign next_val_c  = ramp_step(duty_q, aim_c, step_eff_c);
    assign step_fire_c = running_c && tick_c && (ival_q >= div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= STEP_RST;
            div_q    <= DIV_RST;
            origin_q <= '0;
            ival_q   <= '0;
            bounce_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            div_q    <= div_d;
            origin_q <= origin_d;
            ival_q   <= ival_d;
            bounce_q <= bounce_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        div_d    = div_q;
        origin_d = origin_q;
        ival_d   = ival_q;
        bounce_d = bounce_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;

        // Interval counter: DIV+1 base ticks per step, free-running across FWD/REV turnarounds.
        if (running_c && tick_c) begin
            ival_d = (ival_q >= div_q) ? '0 : ival_q + DATA_W'(1);
        end

        if (step_fire_c) begin
            duty_d = next_val_c;
            if (next_val_c == aim_c) begin
                if (state_q == REV) begin
                    state_d = FWD;
                end else if (bounce_q) begin
                    state_d = REV;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        if (wr_target_c) target_d = wr_c.data;
        if (wr_step_c)   step_d   = wr_c.data;
        if (wr_div_c)    div_d    = wr_c.data;

        // A direct write overrides any concurrent step and cancels a running ramp.
        if (wr_duty_c) begin
            duty_d = wr_c.data;
            if (running_c) begin
                state_d = IDLE;
                abort_d = 1'b1;
                done_d  = 1'b0;
            end
        end

        if (wr_ctrl_c) begin
            bounce_d = wr_c.data[CTRL_BOUNCE_BIT];
            duty_d   = duty_q;
            done_d   = 1'b0;
            if (start_c) begin
                origin_d = duty_q;
                ival_d   = '0;
                if (!running_c && (target_q == duty_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FWD;
                end
            end else if (running_c) begin
                state_d = IDLE;
                abort_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = abort_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: scoreboarded duty changes and done/aborted pulses.
module tb_pwm_ramp_ctrl;
    import pwm_cfg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] duty_out;
    logic       busy, done, aborted;

    pwm_ramp_ctrl #(.TICK_DIV(4), .TICK_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .duty_out (duty_out),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] val; int cyc; } duty_exp_t;
    duty_exp_t duty_sb[$];
    int        done_sb[$];
    int        abort_sb[$];

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev_duty = '0;
    logic [7:0] mdl_duty = '0;

    // Scoreboard monitor: every duty change and every pulse must match a queued expectation.
    always begin
        duty_exp_t e;
        int        c;
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (duty_out !== prev_duty) begin
                checks++;
                if (duty_sb.size() == 0) begin
                    errors++;
                    $display("FAIL duty_change: unexpected %h at cycle %0d", duty_out, cyc);
                end else begin
                    e = duty_sb.pop_front();
                    if (duty_out !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL duty_change: got %h at cycle %0d, want %h at cycle %0d",
                                 duty_out, cyc, e.val, e.cyc);
                    end
                end
                prev_duty = duty_out;
            end
            if (done !== 1'b0) begin
                checks++;
                if (done_sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_pulse: unexpected done=%b at cycle %0d", done, cyc);
                end else begin
                    c = done_sb.pop_front();
                    if (cyc != c) begin
                        errors++;
                        $display("FAIL done_pulse: got cycle %0d, want cycle %0d", cyc, c);
                    end
                end
            end
            if (aborted !== 1'b0) begin
                checks++;
                if (abort_sb.size() == 0) begin
                    errors++;
                    $display("FAIL abort_pulse: unexpected aborted=%b at cycle %0d", aborted, cyc);
                end else begin
                    c = abort_sb.pop_front();
                    if (cyc != c) begin
                        errors++;
                        $display("FAIL abort_pulse: got cycle %0d, want cycle %0d", cyc, c);
                    end
                end
            end
        end
    end

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wr(input logic [6:0] a, input logic [7:0] d, output int n);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        n        = cyc;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic push_duty(input logic [7:0] v, input int c);
        if (v != mdl_duty) duty_sb.push_back('{val: v, cyc: c});
        mdl_duty = v;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (duty_sb.size() == 0 && done_sb.size() == 0 && abort_sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (duty_out !== 8'h00) begin errors++; $display("FAIL reset_duty: got %h want 00", duty_out); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (aborted !== 1'b0)   begin errors++; $display("FAIL reset_aborted: got %b want 0", aborted); end
        rst_n     = 1'b1;
        prev_duty = 8'h00;
        mdl_duty  = 8'h00;
        mon_en    = 1'b1;
    endtask

    task automatic test_ramp_up();
        int n; bit ok;
        wr(ADDR_DUTY, 8'h10, n); push_duty(8'h10, n + 1);
        wr(ADDR_TARGET, 8'h40, n);
        wr(ADDR_STEP, 8'h10, n);
        wr(ADDR_DIV, 8'h01, n);
        wr(ADDR_CTRL, 8'h01, n);
        push_duty(8'h20, n + 9); push_duty(8'h30, n + 17); push_duty(8'h40, n + 25);
        done_sb.push_back(n + 25);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ramp_up_busy: got %b want 1", busy); end
        drain(60, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL ramp_up_drain: got timeout want all events"); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ramp_up_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_saturation();
        int n; bit ok;
        logic [7:0] seq [6] = '{8'hC8, 8'h98, 8'h68, 8'h38, 8'h08, 8'h00};
        wr(ADDR_DUTY, 8'hF8, n); push_duty(8'hF8, n + 1);
        wr(ADDR_TARGET, 8'h00, n);
        wr(ADDR_STEP, 8'h30, n);
        wr(ADDR_DIV, 8'h00, n);
        wr(ADDR_CTRL, 8'h01, n);
        for (int i = 0; i < 6; i++) push_duty(seq[i], n + 5 + 4 * i);
        done_sb.push_back(n + 25);
        drain(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_down_drain: got timeout want all events"); end
        wr(ADDR_DUTY, 8'hF0, n); push_duty(8'hF0, n + 1);
        wr(ADDR_TARGET, 8'hFF, n);
        wr(ADDR_CTRL, 8'h01, n);
        push_duty(8'hFF, n + 5);
        done_sb.push_back(n + 5);
        drain(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_up_drain: got timeout want all events"); end
    endtask

    task automatic test_bounce();
        int n, s; bit ok;
        logic [7:0] seq [7] = '{8'h01, 8'h02, 8'h03, 8'h02, 8'h01, 8'h00, 8'h01};
        wr(ADDR_DUTY, 8'h00, n); push_duty(8'h00, n + 1);
        wr(ADDR_TARGET, 8'h03, n);
        wr(ADDR_STEP, 8'h01, n);
        wr(ADDR_CTRL, 8'h03, n);
        for (int i = 0; i < 7; i++) push_duty(seq[i], n + 5 + 4 * i);
        drain(60, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL bounce_drain: got timeout want all events"); end
        if (busy !== 1'b1) begin errors++; $display("FAIL bounce_busy: got %b want 1", busy); end
        wr(ADDR_CTRL, 8'h00, s);
        abort_sb.push_back(s + 1);
        checks += 2;
        if (busy !== 1'b0)        begin errors++; $display("FAIL bounce_stop_busy: got %b want 0", busy); end
        if (duty_out !== 8'h01)   begin errors++; $display("FAIL bounce_hold: got %h want 01", duty_out); end
        drain(10, ok);
        repeat (20) @(negedge clk);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL bounce_abort_drain: got timeout want aborted pulse"); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bounce_after_stop: got busy %b want 0", busy); end
    endtask

    task automatic test_duty_abort();
        int n, s; bit ok;
        wr(ADDR_DUTY, 8'h00, n); push_duty(8'h00, n + 1);
        wr(ADDR_TARGET, 8'h80, n);
        wr(ADDR_STEP, 8'h10, n);
        wr(ADDR_CTRL, 8'h01, n);
        push_duty(8'h10, n + 5);
        drain(30, ok);
        wr(ADDR_DUTY, 8'h77, s);
        push_duty(8'h77, s + 1);
        abort_sb.push_back(s + 1);
        drain(10, ok);
        repeat (30) @(negedge clk);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL duty_abort_drain: got timeout want all events"); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL duty_abort_busy: got %b want 0", busy); end
        if (duty_out !== 8'h77) begin errors++; $display("FAIL duty_abort_hold: got %h want 77", duty_out); end
    endtask

    task automatic test_step_zero();
        int n; bit ok;
        wr(ADDR_DUTY, 8'h10, n); push_duty(8'h10, n + 1);
        wr(ADDR_TARGET, 8'h12, n);
        wr(ADDR_STEP, 8'h00, n);
        wr(ADDR_CTRL, 8'h01, n);
        push_duty(8'h11, n + 5); push_duty(8'h12, n + 9);
        done_sb.push_back(n + 9);
        drain(40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL step_zero_drain: got timeout want all events"); end
    endtask

    task automatic test_target_equal();
        int n; bit ok;
        wr(ADDR_CTRL, 8'h01, n);
        done_sb.push_back(n + 1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL equal_busy: got %b want 0", busy); end
        drain(10, ok);
        repeat (10) @(negedge clk);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL equal_drain: got timeout want done pulse"); end
        if (busy !== 1'b0) begin errors++; $display("FAIL equal_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_unmapped();
        int n;
        wr(7'h09, 8'h01, n);
        wr(7'h09, 8'h55, n);
        repeat (20) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)      begin errors++; $display("FAIL unmapped_busy: got %b want 0", busy); end
        if (duty_out !== 8'h12) begin errors++; $display("FAIL unmapped_duty: got %h want 12", duty_out); end
    endtask

    task automatic test_reset_mid_ramp();
        int n, c; bit ok;
        wr(ADDR_TARGET, 8'h80, n);
        wr(ADDR_STEP, 8'h01, n);
        wr(ADDR_CTRL, 8'h01, n);
        push_duty(8'h13, n + 5);
        drain(30, ok);
        @(negedge clk);
        #5;
        rst_n = 1'b0;
        c = cyc;
        push_duty(8'h00, c + 1);
        #1;
        checks += 3;
        if (!ok)                begin errors++; $display("FAIL rst_pre_drain: got timeout want step"); end
        if (duty_out !== 8'h00) begin errors++; $display("FAIL rst_async_duty: got %h want 00", duty_out); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_quiet_busy: got %b want 0", busy); end
        if (duty_out !== 8'h00) begin errors++; $display("FAIL rst_quiet_duty: got %h want 00", duty_out); end
        // Reset TARGET=0 equals duty: start completes immediately.
        wr(ADDR_CTRL, 8'h01, n);
        done_sb.push_back(n + 1);
        drain(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_target_drain: got timeout want done"); end
        // Reset STEP=1, DIV=0: unit steps every base tick.
        wr(ADDR_TARGET, 8'h02, n);
        wr(ADDR_CTRL, 8'h01, n);
        push_duty(8'h01, n + 5); push_duty(8'h02, n + 9);
        done_sb.push_back(n + 9);
        drain(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_stepdiv_drain: got timeout want all events"); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_saturation();
        test_bounce();
        test_duty_abort();
        test_step_zero();
        test_target_equal();
        test_unmapped();
        test_reset_mid_ramp();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
